// File: rtl/pipe_front_regs_pkg.sv
// Shared constants and ID/EX bundle layout for the front-end pipeline registers.
package pipe_front_regs_pkg;

    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_0000;
    localparam logic [31:0] NPC_RESET_DEF = 32'h0000_0004;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0100_0000;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam int          CTRL_W_DEF    = 8;

    // Fixed-width part of the ID/EX bundle; ctrl bits of width CTRL_W follow it.
    typedef struct packed {
        logic       l;
        logic       rf_le;
        logic [4:0] rd;
        logic       valid;
    } ex_hdr_t;

    localparam ex_hdr_t EX_HDR_BUBBLE = '0;

endpackage

// File: rtl/pipe_front_regs_pipe_reg.sv
// Generic pipeline register: sync reset value, hold enable, clear-to-bubble.
module pipe_reg #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0,
    parameter logic [W-1:0]   BUBBLE  = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold wins over clear so a frozen stage never loses its contents.
    always_ff @(posedge clk) begin
        if (reset)
            q <= RST_VAL;
        else if (hold)
            q <= q;
        else if (clear)
            q <= BUBBLE;
        else
            q <= d;
    end

endmodule

// File: rtl/pipe_front_regs.sv
// PC/nPC with SPARC-style delayed branch, IF/ID and ID/EX registers, stall counter.
module pipe_front_regs
    import pipe_front_regs_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] NPC_RESET = NPC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          CTRL_W    = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_F,
    input  logic              stall_D,
    input  logic              flush_E,
    input  logic              br_taken_ID,
    input  logic [31:0]       br_target_ID,
    input  logic [31:0]       instr_IF,
    input  logic              L_ID,
    input  logic              RF_LE_ID,
    input  logic [4:0]        RD_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    output logic [31:0]       PC,
    output logic [31:0]       nPC,
    output logic [31:0]       instr_ID,
    output logic [31:0]       PC_ID,
    output logic              valid_ID,
    output logic              L_EX,
    output logic              RF_LE_EX,
    output logic [4:0]        RD_EX,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic [31:0]       PC_EX,
    output logic              valid_EX,
    output logic [15:0]       stall_cnt
);

    localparam int IFID_W = 32 + 32 + 1;
    localparam int EX_W   = $bits(ex_hdr_t) + CTRL_W;

    logic redirect;
    assign redirect = br_taken_ID & valid_ID & ~stall_D;

    always_ff @(posedge clk) begin
        if (reset) begin
            PC  <= PC_RESET;
            nPC <= NPC_RESET;
        end else if (!stall_F) begin
            PC  <= nPC;
            nPC <= redirect ? br_target_ID : nPC + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall_F && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    logic [IFID_W-1:0] ifid_d, ifid_q;
    assign ifid_d = {instr_IF, PC, 1'b1};

    pipe_reg #(
        .W       (IFID_W),
        .RST_VAL ({NOP_INSTR, 32'h0, 1'b0}),
        .BUBBLE  ('0)
    ) u_ifid (
        .clk   (clk),
        .reset (reset),
        .hold  (stall_D),
        .clear (1'b0),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign {instr_ID, PC_ID, valid_ID} = ifid_q;

    ex_hdr_t         ex_hdr_d, ex_hdr_q;
    logic [EX_W-1:0] ex_q;

    always_comb begin
        ex_hdr_d       = EX_HDR_BUBBLE;
        ex_hdr_d.l     = L_ID & valid_ID;
        ex_hdr_d.rf_le = RF_LE_ID & valid_ID;
        ex_hdr_d.rd    = RD_ID;
        ex_hdr_d.valid = valid_ID;
    end

    pipe_reg #(
        .W       (EX_W),
        .RST_VAL ('0),
        .BUBBLE  ({EX_HDR_BUBBLE, {CTRL_W{1'b0}}})
    ) u_idex (
        .clk   (clk),
        .reset (reset),
        .hold  (1'b0),
        .clear (flush_E),
        .d     ({ex_hdr_d, ctrl_ID}),
        .q     (ex_q)
    );

    assign {ex_hdr_q, ctrl_EX} = ex_q;
    assign L_EX     = ex_hdr_q.l;
    assign RF_LE_EX = ex_hdr_q.rf_le;
    assign RD_EX    = ex_hdr_q.rd;
    assign valid_EX = ex_hdr_q.valid;

    // PC_EX follows PC_ID even into a bubble, so it is kept out of the clearable bundle.
    pipe_reg #(
        .W       (32),
        .RST_VAL ('0),
        .BUBBLE  ('0)
    ) u_pc_ex (
        .clk   (clk),
        .reset (reset),
        .hold  (1'b0),
        .clear (1'b0),
        .d     (PC_ID),
        .q     (PC_EX)
    );

endmodule
